reset_sequencer: RTL and testbench

Staged reset release/shutdown controller placed between the trigger/watchdog logic and the acquisition and DAC datapaths. On a run request it releases the RAM writer path first. It then releases the RAM-writer DMA path after a programmable delay, and the DAC generators (Fourier synth, PDM) after a second delay. On stop it asserts a ramp-down phase before resetting the DACs. Faults (watchdog timeout, instant reset) force the DACs into reset immediately and latch until explicitly cleared.

---
 rtl/reset_sequencer_if.sv | 29 ++
 rtl/reset_sequencer.sv | 133 +++++++++++++
 tb/tb_reset_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - control/status bundle between trigger logic and the reset sequencer
interface reset_sequencer_if #(
    parameter int DELAY_W = 8
);
    logic               start;
    logic               fault;
    logic               fault_clear;
    logic [DELAY_W-1:0] ramwriter_delay;
    logic [DELAY_W-1:0] dac_delay;
    logic [DELAY_W-1:0] rampdown_time;
    logic               write_to_ram_aresetn;
    logic               write_to_ramwriter_aresetn;
    logic               fourier_synth_aresetn;
    logic               pdm_aresetn;
    logic               ramp_down;
    logic [7:0]         seq_sts;

    modport master (
        output start, fault, fault_clear, ramwriter_delay, dac_delay, rampdown_time,
        input  write_to_ram_aresetn, write_to_ramwriter_aresetn, fourier_synth_aresetn,
               pdm_aresetn, ramp_down, seq_sts
    );

    modport slave (
        input  start, fault, fault_clear, ramwriter_delay, dac_delay, rampdown_time,
        output write_to_ram_aresetn, write_to_ramwriter_aresetn, fourier_synth_aresetn,
               pdm_aresetn, ramp_down, seq_sts
    );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release/shutdown controller for RAM writer and DAC paths
module reset_sequencer #(
    parameter int TICK_CYCLES = 125000,
    parameter int DELAY_W     = 8
) (
    input  logic              clk,
    input  logic              peripheral_aresetn,
    reset_sequencer_if.slave  seq_if
);
    localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RAM    = 3'd1,
        ST_WRITER = 3'd2,
        ST_RUN    = 3'd3,
        ST_RAMP   = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic               latched_q, latched_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DELAY_W-1:0] tick_q, tick_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic               ram_q, ram_d;
    logic               writer_q, writer_d;
    logic               dac_q, dac_d;
    logic               ramp_q, ramp_d;
    logic               dwell_done;

    // A zero delay still costs one cycle; untimed states load delay 0 so their counters idle.
    assign dwell_done = (delay_q == '0) ||
                        ((tick_q == delay_q - DELAY_W'(1)) && (presc_q == PRESC_MAX));

    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            state_q   <= ST_IDLE;
            latched_q <= 1'b0;
            presc_q   <= '0;
            tick_q    <= '0;
            delay_q   <= '0;
            ram_q     <= 1'b0;
            writer_q  <= 1'b0;
            dac_q     <= 1'b0;
            ramp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            latched_q <= latched_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            delay_q   <= delay_d;
            ram_q     <= ram_d;
            writer_q  <= writer_d;
            dac_q     <= dac_d;
            ramp_q    <= ramp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        latched_d = latched_q;
        presc_d   = presc_q;
        tick_d    = tick_q;
        delay_d   = delay_q;
        ram_d     = 1'b0;
        writer_d  = 1'b0;
        dac_d     = 1'b0;
        ramp_d    = 1'b0;

        case (state_q)
            ST_IDLE:   if (seq_if.start && !latched_q) state_d = ST_RAM;
            ST_RAM: begin
                if (!seq_if.start)   state_d = ST_IDLE;
                else if (dwell_done) state_d = ST_WRITER;
            end
            ST_WRITER: begin
                if (!seq_if.start)   state_d = ST_IDLE;
                else if (dwell_done) state_d = ST_RUN;
            end
            ST_RUN:    if (!seq_if.start) state_d = ST_RAMP;
            ST_RAMP:   if (dwell_done) state_d = ST_IDLE;
            ST_FAULT: begin
                if (!seq_if.fault && !seq_if.start && seq_if.fault_clear) begin
                    state_d   = ST_IDLE;
                    latched_d = 1'b0;
                end
            end
            default:   state_d = ST_IDLE;
        endcase

        if (seq_if.fault && state_q != ST_FAULT) begin
            state_d   = ST_FAULT;
            latched_d = 1'b1;
        end

        if (state_d != state_q) begin
            presc_d = '0;
            tick_d  = '0;
            case (state_d)
                ST_RAM:    delay_d = seq_if.ramwriter_delay;
                ST_WRITER: delay_d = seq_if.dac_delay;
                ST_RAMP:   delay_d = seq_if.rampdown_time;
                default:   delay_d = '0;
            endcase
        end else if (!dwell_done) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick_d  = tick_q + DELAY_W'(1);
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end

        // Outputs follow the next state so they switch on the same edge as the transition.
        case (state_d)
            ST_RAM:    ram_d = 1'b1;
            ST_WRITER: begin ram_d = 1'b1; writer_d = 1'b1; end
            ST_RUN:    begin ram_d = 1'b1; writer_d = 1'b1; dac_d = 1'b1; end
            ST_RAMP:   begin ram_d = 1'b1; writer_d = 1'b1; dac_d = 1'b1; ramp_d = 1'b1; end
            ST_FAULT:  begin ram_d = ram_q; writer_d = writer_q; end
            default:   ;
        endcase
    end

    assign seq_if.write_to_ram_aresetn       = ram_q;
    assign seq_if.write_to_ramwriter_aresetn = writer_q;
    assign seq_if.fourier_synth_aresetn      = dac_q;
    assign seq_if.pdm_aresetn                = dac_q;
    assign seq_if.ramp_down                  = ramp_q;
    assign seq_if.seq_sts                    = {4'b0000, latched_q, state_q};
endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer
module tb_reset_sequencer;
    localparam int TICK = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    reset_sequencer_if #(.DELAY_W(8)) seq_if ();

    reset_sequencer #(.TICK_CYCLES(TICK), .DELAY_W(8)) dut (
        .clk                (clk),
        .peripheral_aresetn (rst_n),
        .seq_if             (seq_if)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    int m_state;
    int m_rem;
    bit m_latch, m_ram, m_wr;

    function automatic logic [12:0] outs();
        return {seq_if.write_to_ram_aresetn, seq_if.write_to_ramwriter_aresetn,
                seq_if.fourier_synth_aresetn, seq_if.pdm_aresetn, seq_if.ramp_down, seq_if.seq_sts};
    endfunction

    function automatic logic [12:0] mk(bit r, bit w, bit d, bit rd, logic [7:0] s);
        return {r, w, d, d, rd, s};
    endfunction

    task automatic edges(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(bit s, bit f, bit c);
        seq_if.start       = s;
        seq_if.fault       = f;
        seq_if.fault_clear = c;
    endtask

    task automatic set_delays(int a, int b, int c);
        seq_if.ramwriter_delay = 8'(a);
        seq_if.dac_delay       = 8'(b);
        seq_if.rampdown_time   = 8'(c);
    endtask

    function automatic int dwell(int n);
        return (n * TICK < 1) ? 1 : n * TICK;
    endfunction

    task automatic model_reset();
        m_state = 0; m_rem = 0; m_latch = 0; m_ram = 0; m_wr = 0;
    endtask

    // Reference: per-state remaining-cycle countdown derived from the dwell rule.
    task automatic model_step();
        int nxt;
        nxt = m_state;
        if (seq_if.fault && m_state != 5) begin
            nxt = 5; m_latch = 1;
        end else begin
            case (m_state)
                0: if (seq_if.start && !m_latch) nxt = 1;
                1: if (!seq_if.start) nxt = 0; else if (m_rem == 1) nxt = 2;
                2: if (!seq_if.start) nxt = 0; else if (m_rem == 1) nxt = 3;
                3: if (!seq_if.start) nxt = 4;
                4: if (m_rem == 1) nxt = 0;
                default: if (!seq_if.fault && !seq_if.start && seq_if.fault_clear) begin
                    nxt = 0; m_latch = 0;
                end
            endcase
        end
        if (nxt != m_state) begin
            case (nxt)
                1: m_rem = dwell(int'(seq_if.ramwriter_delay));
                2: m_rem = dwell(int'(seq_if.dac_delay));
                4: m_rem = dwell(int'(seq_if.rampdown_time));
                default: m_rem = 0;
            endcase
        end else if (m_rem > 0) begin
            m_rem--;
        end
        if (nxt != 5) begin
            m_ram = (nxt >= 1 && nxt <= 4);
            m_wr  = (nxt >= 2 && nxt <= 4);
        end
        m_state = nxt;
    endtask

    function automatic logic [12:0] model_vec();
        return mk(m_ram, m_wr, (m_state == 3 || m_state == 4), (m_state == 4),
                  {4'b0000, m_latch, 3'(m_state)});
    endfunction

    task automatic apply_reset();
        set_in(0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_in(1, 0, 0);
        set_delays(0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (outs() !== 13'h0) begin err_cnt++; $display("FAIL reset_async: got %h exp %h", outs(), 13'h0); end
        edges(3);
        cmp_cnt++;
        if (outs() !== 13'h0) begin err_cnt++; $display("FAIL reset_hold: got %h exp %h", outs(), 13'h0); end
        seq_if.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        edges(1);
        cmp_cnt++;
        if (outs() !== 13'h0) begin err_cnt++; $display("FAIL reset_idle: got %h exp %h", outs(), 13'h0); end
    endtask

    task automatic test_start_sequence();
        set_delays(2, 3, 1);
        set_in(1, 0, 0);
        edges(1);
        cmp_cnt++;
        if (outs() !== mk(1,0,0,0,8'h01)) begin err_cnt++; $display("FAIL seq_ram: got %h exp %h", outs(), mk(1,0,0,0,8'h01)); end
        seq_if.ramwriter_delay = 8'd0;
        edges(7);
        cmp_cnt++;
        if (outs() !== mk(1,0,0,0,8'h01)) begin err_cnt++; $display("FAIL seq_ram_dwell: got %h exp %h", outs(), mk(1,0,0,0,8'h01)); end
        edges(1);
        cmp_cnt++;
        if (outs() !== mk(1,1,0,0,8'h02)) begin err_cnt++; $display("FAIL seq_writer: got %h exp %h", outs(), mk(1,1,0,0,8'h02)); end
        seq_if.dac_delay = 8'd0;
        edges(11);
        cmp_cnt++;
        if (outs() !== mk(1,1,0,0,8'h02)) begin err_cnt++; $display("FAIL seq_writer_dwell: got %h exp %h", outs(), mk(1,1,0,0,8'h02)); end
        edges(1);
        cmp_cnt++;
        if (outs() !== mk(1,1,1,0,8'h03)) begin err_cnt++; $display("FAIL seq_run: got %h exp %h", outs(), mk(1,1,1,0,8'h03)); end
        edges(5);
        seq_if.start = 1'b0;
        edges(1);
        cmp_cnt++;
        if (outs() !== mk(1,1,1,1,8'h04)) begin err_cnt++; $display("FAIL seq_ramp: got %h exp %h", outs(), mk(1,1,1,1,8'h04)); end
        seq_if.start = 1'b1;
        edges(3);
        cmp_cnt++;
        if (outs() !== mk(1,1,1,1,8'h04)) begin err_cnt++; $display("FAIL seq_ramp_dwell: got %h exp %h", outs(), mk(1,1,1,1,8'h04)); end
        seq_if.start = 1'b0;
        edges(1);
        cmp_cnt++;
        if (outs() !== 13'h0) begin err_cnt++; $display("FAIL seq_stop_idle: got %h exp %h", outs(), 13'h0); end
    endtask

    task automatic test_zero_delays();
        set_delays(0, 0, 0);
        set_in(1, 0, 0);
        edges(1);
        cmp_cnt++;
        if (outs() !== mk(1,0,0,0,8'h01)) begin err_cnt++; $display("FAIL zero_ram: got %h exp %h", outs(), mk(1,0,0,0,8'h01)); end
        edges(1);
        cmp_cnt++;
        if (outs() !== mk(1,1,0,0,8'h02)) begin err_cnt++; $display("FAIL zero_writer: got %h exp %h", outs(), mk(1,1,0,0,8'h02)); end
        edges(1);
        cmp_cnt++;
        if (outs() !== mk(1,1,1,0,8'h03)) begin err_cnt++; $display("FAIL zero_run: got %h exp %h", outs(), mk(1,1,1,0,8'h03)); end
        seq_if.start = 1'b0;
        edges(1);
        cmp_cnt++;
        if (outs() !== mk(1,1,1,1,8'h04)) begin err_cnt++; $display("FAIL zero_ramp: got %h exp %h", outs(), mk(1,1,1,1,8'h04)); end
        edges(1);
        cmp_cnt++;
        if (outs() !== 13'h0) begin err_cnt++; $display("FAIL zero_idle: got %h exp %h", outs(), 13'h0); end
    endtask

    task automatic test_stop_mid_writer();
        set_delays(2, 3, 1);
        set_in(1, 0, 0);
        edges(9);
        cmp_cnt++;
        if (outs() !== mk(1,1,0,0,8'h02)) begin err_cnt++; $display("FAIL mid_writer_enter: got %h exp %h", outs(), mk(1,1,0,0,8'h02)); end
        edges(2);
        seq_if.start = 1'b0;
        edges(1);
        cmp_cnt++;
        if (outs() !== 13'h0) begin err_cnt++; $display("FAIL mid_writer_abort: got %h exp %h", outs(), 13'h0); end
        for (int i = 0; i < 16; i++) begin
            edges(1);
            cmp_cnt++;
            if (outs() !== 13'h0) begin err_cnt++; $display("FAIL mid_writer_quiet: got %h exp %h", outs(), 13'h0); end
        end
    endtask

    task automatic test_fault();
        set_delays(0, 0, 0);
        set_in(1, 0, 0);
        edges(3);
        cmp_cnt++;
        if (outs() !== mk(1,1,1,0,8'h03)) begin err_cnt++; $display("FAIL fault_pre_run: got %h exp %h", outs(), mk(1,1,1,0,8'h03)); end
        set_in(1, 1, 0);
        edges(1);
        seq_if.fault = 1'b0;
        cmp_cnt++;
        if (outs() !== mk(1,1,0,0,8'h0D)) begin err_cnt++; $display("FAIL fault_entry: got %h exp %h", outs(), mk(1,1,0,0,8'h0D)); end
        set_in(1, 0, 1);
        edges(1);
        seq_if.fault_clear = 1'b0;
        cmp_cnt++;
        if (outs() !== mk(1,1,0,0,8'h0D)) begin err_cnt++; $display("FAIL fault_clear_with_start: got %h exp %h", outs(), mk(1,1,0,0,8'h0D)); end
        set_in(0, 1, 1);
        edges(1);
        cmp_cnt++;
        if (outs() !== mk(1,1,0,0,8'h0D)) begin err_cnt++; $display("FAIL fault_and_clear: got %h exp %h", outs(), mk(1,1,0,0,8'h0D)); end
        set_in(0, 0, 0);
        edges(1);
        cmp_cnt++;
        if (outs() !== mk(1,1,0,0,8'h0D)) begin err_cnt++; $display("FAIL fault_latched_hold: got %h exp %h", outs(), mk(1,1,0,0,8'h0D)); end
        seq_if.fault_clear = 1'b1;
        edges(1);
        seq_if.fault_clear = 1'b0;
        cmp_cnt++;
        if (outs() !== 13'h0) begin err_cnt++; $display("FAIL fault_cleared: got %h exp %h", outs(), 13'h0); end
    endtask

    task automatic test_async_reset();
        set_delays(0, 0, 0);
        set_in(1, 0, 0);
        edges(3);
        cmp_cnt++;
        if (outs() !== mk(1,1,1,0,8'h03)) begin err_cnt++; $display("FAIL arst_pre_run: got %h exp %h", outs(), mk(1,1,1,0,8'h03)); end
        #3 rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (outs() !== 13'h0) begin err_cnt++; $display("FAIL arst_immediate: got %h exp %h", outs(), 13'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        edges(1);
        cmp_cnt++;
        if (outs() !== mk(1,0,0,0,8'h01)) begin err_cnt++; $display("FAIL arst_restart_ram: got %h exp %h", outs(), mk(1,0,0,0,8'h01)); end
        edges(1);
        cmp_cnt++;
        if (outs() !== mk(1,1,0,0,8'h02)) begin err_cnt++; $display("FAIL arst_restart_writer: got %h exp %h", outs(), mk(1,1,0,0,8'h02)); end
        seq_if.start = 1'b0;
        edges(2);
    endtask

    task automatic test_random();
        apply_reset();
        model_reset();
        set_delays(0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 6) seq_if.start = ~seq_if.start;
            seq_if.fault       = ($urandom_range(99) < 2);
            seq_if.fault_clear = ($urandom_range(99) < 15);
            if ($urandom_range(99) < 10)
                set_delays($urandom_range(3), $urandom_range(3), $urandom_range(3));
            @(posedge clk);
            model_step();
            #1;
            cmp_cnt++;
            if (outs() !== model_vec()) begin
                err_cnt++;
                $display("FAIL random cycle %0d: got %h exp %h", i, outs(), model_vec());
            end
        end
    endtask

    initial begin
        set_in(0, 0, 0);
        set_delays(0, 0, 0);
        test_reset();
        test_start_sequence();
        test_zero_delays();
        test_stop_mid_writer();
        test_fault();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
